alu_cmd_sequencer: RTL
======================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-002 Parameter FP_HOLD, default 2, execute cycles for IEEE754 opcodes 0000/0001/0010 (>=1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at rising edge.
REQ-007 cmd_opcode  input  4  ALU opcode.
REQ-008 cmd_sel  input  1  register select (0=regA, 1=regB).
REQ-009 cmd_adr  input  6  memory address.
REQ-010 cmd_imm  input  32  immediate / A operand.
REQ-011 cmd_bsel  input  2  byte select.
REQ-012 fill_start  input  1  one-cycle request to fill all 64 memory words.
REQ-013 fill_imm  input  32  fill increment value.
REQ-014 alu_A, alu_sel, alu_adr, alu_opcode, alu_bsel  output  32/1/6/4/2  registered drive to ALU ports A/sel/adr/opcode/bsel.
REQ-015 alu_en  output  1  ALU state-update qualifier; ALU integration SHALL update registers/memory only when high.
REQ-016 alu_out  input  32  ALU result.
REQ-017 rsp_valid  output  1  result-valid pulse, one per command.
REQ-018 rsp_data  output  32  equals alu_out while rsp_valid=1.
REQ-019 busy  output  1  high in any state other than IDLE or FIFO non-empty.
REQ-020 fill_done  output  1  one-cycle pulse at fill completion.

Function
REQ-021 FSM states SHALL be IDLE, EXEC, WB, FILL.
REQ-022 cmd_ready SHALL equal (FIFO count < DEPTH) & (state != FILL) & !rst, independent of same-cycle pop.
REQ-023 FIFO SHALL be in-order; pointers wrap modulo DEPTH; simultaneous push and pop SHALL keep count unchanged.
REQ-024 IDLE with FIFO non-empty: pop head at edge, load alu_* fields, enter EXEC; hold counter = FP_HOLD for opcodes 0000-0010, else 1.
REQ-025 EXEC: alu_en=1 for exactly hold-counter cycles, alu_* stable; then enter WB.
REQ-026 WB: one cycle, alu_en=0, rsp_valid=1, rsp_data=alu_out; next edge pop into EXEC if FIFO non-empty, else IDLE.
REQ-027 Latency: command pushed at edge 0 with FIFO empty and IDLE -> EXEC cycles 1..H, rsp_valid in cycle H+1.
REQ-028 fill_start SHALL be honoured only in IDLE with FIFO empty and cmd_valid=0; otherwise ignored (not queued).
REQ-029 FILL: capture fill_imm; for i=0..63 issue opcode 0111 (add immediate) then 1110 (store double), alu_sel=1, alu_adr=i, alu_A=captured value, one cycle each, alu_en=1; 128 cycles total.
REQ-030 After i=63 store cycle: fill_done=1 for one cycle, alu_en=0, return to IDLE; no rsp_valid during FILL.
REQ-031 alu_* outputs SHALL hold last driven values whenever alu_en=0.

Reset
REQ-032 rst SHALL asynchronously force: state IDLE, FIFO empty, alu_A/alu_sel/alu_adr/alu_opcode/alu_bsel=0, alu_en=0, rsp_valid=0, fill_done=0, busy=0.
REQ-033 rst mid-EXEC or mid-FILL SHALL abort the operation with no rsp_valid/fill_done and drop all queued commands; cmd_ready=1 on first cycle after release.

Verification
REQ-034 Reset: assert rst during traffic -> all outputs zero immediately, cmd_ready=1 after release, FIFO empty.
REQ-035 Single op: push opcode 0011, adr 5 at edge 0 -> alu_en=1 cycle 1 with opcode 0011/adr 5, rsp_valid cycle 2 with rsp_data=alu_out.
REQ-036 FP op: FP_HOLD=3, push opcode 0010 -> alu_en high 3 cycles, rsp_valid cycle 4, exactly one response.
REQ-037 Fill: fill_imm=2 -> 128 alu_en cycles alternating 0111/1110 over adr 0..63, cmd_ready=0 throughout, fill_done once; memory model mem[i]=2*(i+1).
REQ-038 Backpressure: push 6 commands continuously -> cmd_ready low when count=4, no command lost, responses in push order.
REQ-039 fill_start while busy or FIFO non-empty -> ignored, no FILL entry, no fill_done.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of an ALU: queues commands in an in-order FIFO,
// holds each on the ALU ports for its execute time, reports one response per
// command, and can run a 64-word memory fill sequence when idle.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FP_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic        cmd_sel,
  input  logic [5:0]  cmd_adr,
  input  logic [31:0] cmd_imm,
  input  logic [1:0]  cmd_bsel,
  input  logic        fill_start,
  input  logic [31:0] fill_imm,
  output logic [31:0] alu_A,
  output logic        alu_sel,
  output logic [5:0]  alu_adr,
  output logic [3:0]  alu_opcode,
  output logic [1:0]  alu_bsel,
  output logic        alu_en,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        fill_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(FP_HOLD + 1);
  localparam int unsigned SW = 7;

  localparam logic [3:0] OP_ADDI  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1110;
  localparam logic [3:0] OP_FPMAX = 4'b0010;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        sel;
    logic [5:0]  adr;
    logic [31:0] imm;
    logic [1:0]  bsel;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_FILL} state_t;

  state_t        r_state, w_state_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic [SW-1:0] r_step, w_step_nxt;
  cmd_t          r_alu, w_alu_nxt;
  logic          r_alu_en, w_alu_en_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic          r_fill_done, w_fill_done_nxt;

  cmd_t          r_fifo [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  cmd_t          w_cmd_in, w_head;
  logic [HW-1:0] w_head_hold;

  assign w_cmd_in    = '{opcode: cmd_opcode, sel: cmd_sel, adr: cmd_adr,
                         imm: cmd_imm, bsel: cmd_bsel};
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_head_hold = (w_head.opcode <= OP_FPMAX) ? HW'(FP_HOLD) : HW'(1);

  assign cmd_ready = (r_count < CW'(DEPTH)) && (r_state != S_FILL) && !rst;
  assign w_push    = cmd_valid && cmd_ready;
  assign busy      = (r_state != S_IDLE) || (r_count != '0);

  assign alu_A      = r_alu.imm;
  assign alu_sel    = r_alu.sel;
  assign alu_adr    = r_alu.adr;
  assign alu_opcode = r_alu.opcode;
  assign alu_bsel   = r_alu.bsel;
  assign alu_en     = r_alu_en;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_valid ? alu_out : '0;
  assign fill_done  = r_fill_done;

  // FIFO payload storage; data needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_cmd_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state and registered ALU / response drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_step      <= '0;
      r_alu       <= '0;
      r_alu_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_step      <= w_step_nxt;
      r_alu       <= w_alu_nxt;
      r_alu_en    <= w_alu_en_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_fill_done <= w_fill_done_nxt;
    end
  end

  // Next-state and next-output decode; alu_* fields hold unless reloaded
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_step_nxt      = r_step;
    w_alu_nxt       = r_alu;
    w_alu_en_nxt    = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_fill_done_nxt = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      S_IDLE, S_WB: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_alu_nxt    = w_head;
          w_hold_nxt   = w_head_hold;
          w_alu_en_nxt = 1'b1;
          w_state_nxt  = S_EXEC;
        end else if ((r_state == S_IDLE) && fill_start && !cmd_valid) begin
          w_alu_nxt.opcode = OP_ADDI;
          w_alu_nxt.sel    = 1'b1;
          w_alu_nxt.adr    = '0;
          w_alu_nxt.imm    = fill_imm;
          w_step_nxt       = '0;
          w_alu_en_nxt     = 1'b1;
          w_state_nxt      = S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (r_hold <= HW'(1)) begin
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_WB;
        end else begin
          w_hold_nxt   = r_hold - HW'(1);
          w_alu_en_nxt = 1'b1;
        end
      end
      S_FILL: begin
        if (r_step == {SW{1'b1}}) begin
          w_fill_done_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          // step bit 0 picks add vs store, upper bits are the word address
          w_step_nxt       = r_step + SW'(1);
          w_alu_nxt.opcode = w_step_nxt[0] ? OP_STORE : OP_ADDI;
          w_alu_nxt.adr    = w_step_nxt[SW-1:1];
          w_alu_en_nxt     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
